// File: rtl/cpu_state_seq_if.sv
// cpu_state_seq_if: control inputs and stage strobes of the sequencer.
// master drives start/quit/stall/dmem status; slave is the sequencer.
interface cpu_state_seq_if;
  logic        cpu_start;
  logic        quit_cmd;
  logic        stall;
  logic        dmem_acc_ex;
  logic        dmem_ack;
  logic        cpu_stat_pc;
  logic        cpu_stat_if;
  logic        cpu_stat_rf;
  logic        cpu_stat_ex;
  logic        cpu_stat_dmem;
  logic        cpu_stat_wb;
  logic        cpu_running;
  logic        dmem_timeout;
  logic [31:0] retire_cnt;

  modport master (
    output cpu_start, quit_cmd, stall,
    output dmem_acc_ex, dmem_ack,
    input  cpu_stat_pc, cpu_stat_if,
    input  cpu_stat_rf, cpu_stat_ex,
    input  cpu_stat_dmem, cpu_stat_wb,
    input  cpu_running, dmem_timeout,
    input  retire_cnt
  );

  modport slave (
    input  cpu_start, quit_cmd, stall,
    input  dmem_acc_ex, dmem_ack,
    output cpu_stat_pc, cpu_stat_if,
    output cpu_stat_rf, cpu_stat_ex,
    output cpu_stat_dmem, cpu_stat_wb,
    output cpu_running, dmem_timeout,
    output retire_cnt
  );
endinterface

// File: rtl/cpu_state_seq.sv
// cpu_state_seq: multi-cycle PC->IF->RF->EX->DMEM->WB sequencer, RV32I core.
// Option CPU_STATE_SEQ_SKIP_DMEM_EN: non-memory instructions bypass DMEM.
module cpu_state_seq #(
  parameter int DMEM_TO_CYC = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_state_seq_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_PC, S_IF, S_RF,
    S_EX, S_DMEM, S_WB
  } state_t;

  localparam logic [7:0] TO_LAST =
    8'(DMEM_TO_CYC - 1);

  state_t      state_q, state_d;
  logic        acc_q, acc_d;
  logic        ack_pend_q, ack_pend_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        quit_pend_q, quit_pend_d;
  logic        timeout_q, timeout_d;
  logic [31:0] retire_q, retire_d;
  logic        ack_any;

  assign ack_any = bus.dmem_ack | ack_pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= 1'b0;
      ack_pend_q  <= 1'b0;
      to_cnt_q    <= '0;
      quit_pend_q <= 1'b0;
      timeout_q   <= 1'b0;
      retire_q    <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ack_pend_q  <= ack_pend_d;
      to_cnt_q    <= to_cnt_d;
      quit_pend_q <= quit_pend_d;
      timeout_q   <= timeout_d;
      retire_q    <= retire_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ack_pend_d  = ack_pend_q;
    to_cnt_d    = to_cnt_q;
    quit_pend_d = quit_pend_q;
    timeout_d   = 1'b0;
    retire_d    = retire_q;
    if (state_q != S_IDLE && bus.quit_cmd)
      quit_pend_d = 1'b1;
    if (state_q == S_IDLE) begin
      if (bus.cpu_start)
        state_d = S_PC;
    end else if (bus.stall) begin
      // an ack seen while frozen must not be lost
      if (state_q == S_DMEM && bus.dmem_ack)
        ack_pend_d = 1'b1;
    end else begin
      unique case (state_q)
        S_PC: state_d = S_IF;
        S_IF: state_d = S_RF;
        S_RF: state_d = S_EX;
        S_EX: begin
          acc_d      = bus.dmem_acc_ex;
          to_cnt_d   = '0;
          ack_pend_d = 1'b0;
`ifdef CPU_STATE_SEQ_SKIP_DMEM_EN
          state_d = bus.dmem_acc_ex ? S_DMEM
                                    : S_WB;
`else
          state_d = S_DMEM;
`endif
        end
        S_DMEM: begin
          if (!acc_q || ack_any) begin
            state_d    = S_WB;
            ack_pend_d = 1'b0;
          end else if (to_cnt_q == TO_LAST) begin
            state_d   = S_WB;
            timeout_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
        end
        S_WB: begin
          retire_d = retire_q + 32'd1;
          if (quit_pend_q) begin
            state_d     = S_IDLE;
            quit_pend_d = 1'b0;
          end else begin
            state_d = S_PC;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.cpu_stat_pc   = state_q == S_PC;
  assign bus.cpu_stat_if   = state_q == S_IF;
  assign bus.cpu_stat_rf   = state_q == S_RF;
  assign bus.cpu_stat_ex   = state_q == S_EX;
  assign bus.cpu_stat_dmem = state_q == S_DMEM;
  assign bus.cpu_stat_wb   = state_q == S_WB;
  assign bus.cpu_running   = state_q != S_IDLE;
  assign bus.dmem_timeout  = timeout_q;
  assign bus.retire_cnt    = retire_q;
endmodule

// File: tb/tb_cpu_state_seq.sv
// tb_cpu_state_seq: directed scenarios plus randomized run against
// a stage-number reference model of the instruction sequencer.
module tb_cpu_state_seq;
  localparam int TO = 16;
`ifdef CPU_STATE_SEQ_SKIP_DMEM_EN
  localparam int P = 5;
  int seq[6] = '{1, 2, 3, 4, 6, 0};
  localparam bit SKIP = 1'b1;
`else
  localparam int P = 6;
  int seq[6] = '{1, 2, 3, 4, 5, 6};
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cpu_state_seq_if bus();

  cpu_state_seq #(.DMEM_TO_CYC(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // model: stage 0 idle, 1..6 = PC,IF,RF,EX,DMEM,WB
  int          m_st;
  bit          m_acc, m_ackp, m_quit, m_to;
  int          m_wait;
  logic [31:0] m_ret;

  function automatic void model_reset();
    m_st = 0; m_acc = 0; m_ackp = 0;
    m_quit = 0; m_to = 0; m_wait = 0;
    m_ret = '0;
  endfunction

  function automatic void model_step(
    bit st, bit q, bit stl, bit acc, bit ack);
    int nx;
    bit qold;
    nx = m_st;
    qold = m_quit;
    m_to = 0;
    if (m_st == 0) begin
      if (st) nx = 1;
    end else begin
      if (q) m_quit = 1;
      if (stl) begin
        if (m_st == 5 && ack) m_ackp = 1;
      end else begin
        case (m_st)
          1, 2, 3: nx = m_st + 1;
          4: begin
            m_acc = acc; m_wait = 0; m_ackp = 0;
            nx = (SKIP && !acc) ? 6 : 5;
          end
          5: begin
            m_wait++;
            if (!m_acc || ack || m_ackp) nx = 6;
            else if (m_wait == TO) begin
              nx = 6; m_to = 1;
            end
            if (nx == 6) m_ackp = 0;
          end
          6: begin
            m_ret = m_ret + 1;
            if (qold) begin nx = 0; m_quit = 0; end
            else nx = 1;
          end
          default: ;
        endcase
      end
    end
    m_st = nx;
  endfunction

  function automatic logic [5:0] m_strobes();
    logic [5:0] v;
    v = '0;
    if (m_st != 0) v = 6'b100000 >> (m_st - 1);
    return v;
  endfunction

  function automatic logic [5:0] strobes();
    return {bus.cpu_stat_pc, bus.cpu_stat_if,
            bus.cpu_stat_rf, bus.cpu_stat_ex,
            bus.cpu_stat_dmem, bus.cpu_stat_wb};
  endfunction

  task automatic tick(bit st, bit q, bit stl,
                      bit acc, bit ack);
    bus.cpu_start   = st;
    bus.quit_cmd    = q;
    bus.stall       = stl;
    bus.dmem_acc_ex = acc;
    bus.dmem_ack    = ack;
    @(posedge clk);
    model_step(st, q, stl, acc, ack);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cpu_start = 0; bus.quit_cmd = 0;
    bus.stall = 0; bus.dmem_acc_ex = 0;
    bus.dmem_ack = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (strobes() !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 000000",
               strobes());
    end
    checks++;
    if (bus.cpu_running !== 1'b0 ||
        bus.dmem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_run_to got %b%b exp 00",
               bus.cpu_running, bus.dmem_timeout);
    end
    checks++;
    if (bus.retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_retire got %h exp 0",
               bus.retire_cnt);
    end
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (strobes() !== 6'b0 ||
        bus.cpu_running !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got %b run %b exp 0",
               strobes(), bus.cpu_running);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick(0, 0, 0, 0, 0);
    checks++;
    if (bus.cpu_running !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got %b exp 0",
               bus.cpu_running);
    end
  endtask

  task automatic test_basic_loop();
    logic [5:0] want;
    do_reset();
    tick(1, 0, 0, 0, 0);
    for (int k = 0; k < 2 * P; k++) begin
      want = 6'b100000 >> (seq[k % P] - 1);
      checks++;
      if (strobes() !== want) begin
        errors++;
        $display("FAIL basic_strobe k=%0d got %b exp %b",
                 k, strobes(), want);
      end
      if (k == P) begin
        checks++;
        if (bus.retire_cnt !== 32'd1) begin
          errors++;
          $display("FAIL basic_retire got %0d exp 1",
                   bus.retire_cnt);
        end
      end
      tick(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_dmem_ack();
    int n;
    bit to_seen;
    n = 0; to_seen = 0;
    do_reset();
    tick(1, 0, 0, 1, 0);
    repeat (4) tick(0, 0, 0, 1, 0);
    while (bus.cpu_stat_dmem === 1'b1 && n < 40) begin
      n++;
      tick(0, 0, 0, 1, m_wait == 3);
      if (bus.dmem_timeout === 1'b1) to_seen = 1;
    end
    checks++;
    if (n !== 4 || bus.cpu_stat_wb !== 1'b1) begin
      errors++;
      $display("FAIL ack_dmem_len got %0d wb %b exp 4 1",
               n, bus.cpu_stat_wb);
    end
    checks++;
    if (to_seen !== 1'b0) begin
      errors++;
      $display("FAIL ack_timeout got 1 exp 0");
    end
    tick(0, 0, 0, 0, 0);
    checks++;
    if (bus.retire_cnt !== 32'd1 ||
        bus.cpu_stat_pc !== 1'b1) begin
      errors++;
      $display("FAIL ack_retire got %0d pc %b exp 1 1",
               bus.retire_cnt, bus.cpu_stat_pc);
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    do_reset();
    tick(1, 0, 0, 1, 0);
    repeat (4) tick(0, 0, 0, 1, 0);
    while (bus.cpu_stat_dmem === 1'b1 && n < 40) begin
      n++;
      tick(0, 0, 0, 1, 0);
    end
    checks++;
    if (n !== TO || bus.cpu_stat_wb !== 1'b1) begin
      errors++;
      $display("FAIL to_len got %0d wb %b exp %0d 1",
               n, bus.cpu_stat_wb, TO);
    end
    checks++;
    if (bus.dmem_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_pulse got 0 exp 1");
    end
    tick(0, 0, 0, 0, 0);
    checks++;
    if (bus.dmem_timeout !== 1'b0 ||
        bus.cpu_stat_pc !== 1'b1) begin
      errors++;
      $display("FAIL to_after got to %b pc %b exp 0 1",
               bus.dmem_timeout, bus.cpu_stat_pc);
    end
  endtask

  task automatic test_quit();
    do_reset();
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 12 && bus.cpu_running; i++)
      tick(0, 0, 0, 0, 0);
    checks++;
    if (bus.cpu_running !== 1'b0 ||
        strobes() !== 6'b0 ||
        bus.retire_cnt !== 32'd1) begin
      errors++;
      $display("FAIL quit_idle run %b st %b ret %0d exp 0 0 1",
               bus.cpu_running, strobes(), bus.retire_cnt);
    end
    tick(0, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    checks++;
    if (strobes() !== 6'b100000) begin
      errors++;
      $display("FAIL quit_restart got %b exp 100000",
               strobes());
    end
    repeat (P) tick(0, 0, 0, 0, 0);
    checks++;
    if (strobes() !== 6'b100000 ||
        bus.retire_cnt !== 32'd2) begin
      errors++;
      $display("FAIL quit_discard got %b ret %0d exp 100000 2",
               strobes(), bus.retire_cnt);
    end
    tick(1, 0, 0, 0, 0);
    checks++;
    if (strobes() !== 6'b010000) begin
      errors++;
      $display("FAIL start_running got %b exp 010000",
               strobes());
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(1, 0, 0, 1, 0);
    repeat (4) tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1, 1, i == 1);
      checks++;
      if (strobes() !== 6'b000010) begin
        errors++;
        $display("FAIL stall_hold i=%0d got %b exp 000010",
                 i, strobes());
      end
    end
    tick(0, 0, 0, 1, 0);
    checks++;
    if (bus.cpu_stat_wb !== 1'b1 ||
        bus.dmem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL stall_exit wb %b to %b exp 1 0",
               bus.cpu_stat_wb, bus.dmem_timeout);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.retire_q = 32'hFFFF_FFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.retire_q;
    m_ret = 32'hFFFF_FFFE;
    #1;
    checks++;
    if (bus.retire_cnt !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL wrap_preload got %h exp fffffffe",
               bus.retire_cnt);
    end
    @(negedge clk);
    tick(1, 0, 0, 0, 0);
    repeat (P) tick(0, 0, 0, 0, 0);
    checks++;
    if (bus.retire_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_max got %h exp ffffffff",
               bus.retire_cnt);
    end
    repeat (P) tick(0, 0, 0, 0, 0);
    checks++;
    if (bus.retire_cnt !== 32'd0 ||
        bus.cpu_stat_pc !== 1'b1) begin
      errors++;
      $display("FAIL wrap_zero got %h pc %b exp 0 1",
               bus.retire_cnt, bus.cpu_stat_pc);
    end
  endtask

  task automatic test_random();
    logic [39:0] got, want;
    bit ack;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      ack = (m_st == 5) && ($urandom_range(99) < 8);
      tick($urandom_range(99) < 10,
           $urandom_range(99) < 4,
           $urandom_range(99) < 20,
           $urandom_range(1) == 1, ack);
      got  = {strobes(), bus.cpu_running,
              bus.dmem_timeout, bus.retire_cnt};
      want = {m_strobes(), m_st != 0, m_to, m_ret};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random c=%0d got %h exp %h",
                 c, got, want);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_loop();
    test_dmem_ack();
    test_timeout();
    test_quit();
    test_stall();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
